// File: rtl/fb_pixel_writer_if.sv
// Pixel-stream and framebuffer write-port bundle for fb_pixel_writer.
// master drives pixel beats and wr_ready; slave is the writer itself.
interface fb_pixel_writer_if #(
  parameter int X_WIRE_WIDTH = 11,
  parameter int Y_WIRE_WIDTH = 10,
  parameter int ADDR_WIDTH   = 13
);
  logic                    in_valid;
  logic [X_WIRE_WIDTH-1:0] hpos;
  logic [Y_WIRE_WIDTH-1:0] vpos;
  logic [2:0]              rgb;
  logic                    fifofull;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [2:0]              wr_data;
  logic                    wr_ready;
  logic                    frame_done;
  logic [15:0]             drop_cnt;

  modport master (
    output in_valid, hpos, vpos, rgb, wr_ready,
    input  fifofull, wr_en, wr_addr, wr_data,
    input  frame_done, drop_cnt
  );

  modport slave (
    input  in_valid, hpos, vpos, rgb, wr_ready,
    output fifofull, wr_en, wr_addr, wr_data,
    output frame_done, drop_cnt
  );
endinterface

// File: rtl/fb_pixel_writer.sv
// Buffers pixel beats in a FIFO and writes downscaled cells to the framebuffer.
// Define FBW_DROP_COUNT_EN to bounds-check coordinates and count dropped beats.
module fb_pixel_writer #(
  parameter int RESOLUTION_H = 1280,
  parameter int RESOLUTION_V = 960,
  parameter int SCALE_SHIFT  = 4,
  parameter int X_WIRE_WIDTH = 11,
  parameter int Y_WIRE_WIDTH = 10,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_WIDTH   = 13
) (
  input logic               clk,
  input logic               rst,
  fb_pixel_writer_if.slave  io_pix
);
  localparam int CW   = RESOLUTION_H >> SCALE_SHIFT;
  localparam int CH   = RESOLUTION_V >> SCALE_SHIFT;
  localparam int LAST = CW * CH - 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int BW   = X_WIRE_WIDTH + Y_WIRE_WIDTH + 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_WRITE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [BW-1:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CNTW-1:0] r_count;
  logic [CNTW-1:0] w_count_nxt;
  logic            r_full;
  logic [BW-1:0]   r_beat;

  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [2:0]            r_wr_data;
  logic                  r_frame_done;

  logic w_push;
  logic w_pop;
  logic w_load;
  logic w_done;

  logic [X_WIRE_WIDTH-1:0] w_hpos;
  logic [Y_WIRE_WIDTH-1:0] w_vpos;
  logic [2:0]              w_rgb;
  logic [X_WIRE_WIDTH-1:0] w_cx;
  logic [Y_WIRE_WIDTH-1:0] w_cy;
  logic [ADDR_WIDTH-1:0]   w_addr;

  assign {w_hpos, w_vpos, w_rgb} = r_beat;
  assign w_cx = w_hpos >> SCALE_SHIFT;
  assign w_cy = w_vpos >> SCALE_SHIFT;
  assign w_addr = ADDR_WIDTH'(32'(w_cy) * 32'(CW) + 32'(w_cx));

  // fifofull is registered, so a pop never frees a slot in the same cycle
  assign w_push = io_pix.in_valid & ~r_full;
  assign w_count_nxt = r_count
                     + {{PW{1'b0}}, w_push}
                     - {{PW{1'b0}}, w_pop};

`ifdef FBW_DROP_COUNT_EN
  logic        w_in_range;
  logic        w_drop;
  logic [15:0] r_drop_cnt;

  assign w_in_range = (32'(w_cx) < 32'(CW))
                    && (32'(w_cy) < 32'(CH));
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_done      = 1'b0;
`ifdef FBW_DROP_COUNT_EN
    w_drop      = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
`ifdef FBW_DROP_COUNT_EN
        if (!w_in_range) begin
          w_drop      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_load      = 1'b1;
          w_state_nxt = S_WRITE;
        end
`else
        w_load      = 1'b1;
        w_state_nxt = S_WRITE;
`endif
      end
      S_WRITE: begin
        if (io_pix.wr_ready) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= {io_pix.hpos, io_pix.vpos, io_pix.rgb};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_beat       <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNTW'(FIFO_DEPTH));
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_beat <= r_mem[r_rptr];
      end
      if (w_load) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_rgb;
      end
      if (w_done && r_wr_addr == ADDR_WIDTH'(LAST))
        r_frame_done <= 1'b1;
    end
  end

`ifdef FBW_DROP_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 16'hFFFF)
      r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign io_pix.drop_cnt = r_drop_cnt;
`else
  assign io_pix.drop_cnt = '0;
`endif

  assign io_pix.fifofull   = r_full;
  assign io_pix.wr_en      = (r_state == S_WRITE);
  assign io_pix.wr_addr    = r_wr_addr;
  assign io_pix.wr_data    = r_wr_data;
  assign io_pix.frame_done = r_frame_done;
endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer with a queue-based write model.
// Follows FBW_DROP_COUNT_EN the same way the design does.
module tb_fb_pixel_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  fb_pixel_writer_if io ();

  fb_pixel_writer dut (
    .clk    (clk),
    .rst    (rst),
    .io_pix (io)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  writes_seen = 0;
  int  exp_drop = 0;
  bit  exp_fd = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Model: which cell a beat lands in, straight from the coordinate rules
  function automatic void model_push(input int h, input int v,
                                     input int c);
    int cx;
    int cy;
    wr_t w;
    cx = h / 16;
    cy = v / 16;
`ifdef FBW_DROP_COUNT_EN
    if (cx >= 80 || cy >= 60) begin
      exp_drop++;
      return;
    end
`endif
    w.addr = (cy * 80 + cx) % 8192;
    w.data = c;
    exp_q.push_back(w);
  endfunction

  // Compare process: every cycle out of reset
  initial begin
    bit          prev_stall;
    logic [12:0] prev_addr;
    logic [2:0]  prev_data;
    wr_t         w;
    prev_stall = 0;
    prev_addr = '0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp_fd = 0;
        exp_drop = 0;
        prev_stall = 0;
      end else begin
        chk("frame_done", 32'(io.frame_done), 32'(exp_fd));
        if (prev_stall) begin
          chk("stall_wr_en", 32'(io.wr_en), 32'd1);
          chk("stall_addr", 32'(io.wr_addr), 32'(prev_addr));
          chk("stall_data", 32'(io.wr_data), 32'(prev_data));
        end
        if (io.wr_en && io.wr_ready) begin
          writes_seen++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write actual_addr=%0d required=none",
                     io.wr_addr);
          end else begin
            w = exp_q.pop_front();
            chk("wr_addr", 32'(io.wr_addr), 32'(w.addr));
            chk("wr_data", 32'(io.wr_data), 32'(w.data));
            if (w.addr == 4799) exp_fd = 1;
          end
        end
        prev_stall = io.wr_en && !io.wr_ready;
        prev_addr = io.wr_addr;
        prev_data = io.wr_data;
        if (io.in_valid && !io.fifofull)
          model_push(int'(io.hpos), int'(io.vpos), int'(io.rgb));
      end
    end
  end

  task automatic send_beat(input int h, input int v, input int c);
    bit ok;
    ok = 0;
    io.hpos = 11'(h);
    io.vpos = 10'(v);
    io.rgb = 3'(c);
    io.in_valid = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (!io.fifofull) ok = 1;
      @(posedge clk);
      #1;
    end
    io.in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_wr_en(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!io.wr_en && n < 100);
    if (!io.wr_en) chk("wr_en_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int acc;
    int ws;
    io.in_valid = 1'b0;
    io.hpos = '0;
    io.vpos = '0;
    io.rgb = '0;
    io.wr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_fifofull", 32'(io.fifofull), 32'd0);
    chk("rst_wr_en", 32'(io.wr_en), 32'd0);
    chk("rst_wr_addr", 32'(io.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(io.wr_data), 32'd0);
    chk("rst_frame_done", 32'(io.frame_done), 32'd0);
    chk("rst_drop_cnt", 32'(io.drop_cnt), 32'd0);
    @(posedge clk);
    #1;

    // Single beat latency and cell address
    io.wr_ready = 1'b1;
    send_beat(32, 48, 5);
    wait_wr_en(n);
    chk("latency", 32'(n), 32'd3);
    chk("single_addr", 32'(io.wr_addr), 32'd242);
    chk("single_data", 32'(io.wr_data), 32'd5);
    @(negedge clk);
    chk("single_pulse", 32'(io.wr_en), 32'd0);
    @(posedge clk);
    #1;

    // Stall in WRITE for 10 cycles
    io.wr_ready = 1'b0;
    send_beat(160, 160, 3);
    wait_wr_en(n);
    repeat (10) @(negedge clk);
    chk("stall_held_en", 32'(io.wr_en), 32'd1);
    chk("stall_held_addr", 32'(io.wr_addr), 32'd810);
    @(posedge clk);
    #1;

    // Fill the FIFO behind the stalled write
    acc = 0;
    io.in_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      io.hpos = 11'(acc * 64 + 3);
      io.vpos = 10'(acc * 48 + 7);
      io.rgb = 3'(acc % 8);
      @(negedge clk);
      if (!io.fifofull) acc++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("bp_accepted", 32'(acc), 32'd16);
    chk("bp_fifofull", 32'(io.fifofull), 32'd1);
    @(posedge clk);
    #1;
    io.wr_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (io.fifofull && n < 20);
    chk("full_release", 32'(n), 32'd3);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || io.wr_en) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drained", 32'(exp_q.size()), 32'd0);
    chk("drain_writes", 32'(writes_seen), 32'd19);
    @(posedge clk);
    #1;

    // Last cell of the frame
    chk("fd_before", 32'(io.frame_done), 32'd0);
    send_beat(1279, 959, 6);
    wait_wr_en(n);
    chk("last_addr", 32'(io.wr_addr), 32'd4799);
    @(negedge clk);
    chk("fd_set", 32'(io.frame_done), 32'd1);
    @(posedge clk);
    #1;
    send_beat(0, 0, 1);
    wait_wr_en(n);
    repeat (5) @(negedge clk);
    chk("fd_sticky", 32'(io.frame_done), 32'd1);
    @(posedge clk);
    #1;

    // Out-of-range column
    ws = writes_seen;
    send_beat(1300, 0, 2);
`ifdef FBW_DROP_COUNT_EN
    repeat (10) @(negedge clk);
    chk("oor_no_write", 32'(writes_seen), 32'(ws));
    chk("oor_drop_cnt", 32'(io.drop_cnt), 32'd1);
`else
    wait_wr_en(n);
    chk("oor_addr", 32'(io.wr_addr), 32'd81);
    repeat (3) @(negedge clk);
    chk("oor_drop_cnt", 32'(io.drop_cnt), 32'd0);
`endif
    chk("drop_model", 32'(io.drop_cnt), 32'(exp_drop));
    @(posedge clk);
    #1;

    // Reset with a stalled write and 5 queued beats
    io.wr_ready = 1'b0;
    acc = 0;
    io.in_valid = 1'b1;
    for (int c = 0; c < 12 && acc < 6; c++) begin
      io.hpos = 11'(acc * 16);
      io.vpos = 10'(acc * 16);
      io.rgb = 3'(acc + 1);
      @(negedge clk);
      if (!io.fifofull) acc++;
      @(posedge clk);
      #1;
    end
    io.in_valid = 1'b0;
    wait_wr_en(n);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_wr_en", 32'(io.wr_en), 32'd0);
    chk("mrst_fifofull", 32'(io.fifofull), 32'd0);
    chk("mrst_frame_done", 32'(io.frame_done), 32'd0);
    chk("mrst_drop_cnt", 32'(io.drop_cnt), 32'd0);
    @(posedge clk);
    #1;
    io.wr_ready = 1'b1;
    ws = writes_seen;
    repeat (20) @(negedge clk);
    chk("mrst_no_writes", 32'(writes_seen), 32'(ws));
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
